ram_clearable: RTL

Parametrised successor to the fixed-size Hack RAM blocks: a single-port WIDTH×2^ADDR_BITS word memory with the same load/address/in/out contract. It adds a hardware clear engine, so reset or an explicit `clear` request zeroes every word, one word per clock. It also has an optional registered read port. It sits wherever the design previously instantiated a fixed RAM8/RAM64/RAM512-style block and needs deterministic contents after reset without simulation-only initialisation.

---
 rtl/ram_clearable.sv | 114 +++++++++++
 1 files changed

// File: rtl/ram_clearable.sv
// Single-port WIDTH x 2^ADDR_BITS RAM with a hardware clear engine that zeroes one word per clock
// after reset or a clear request, and an optional registered read port.
module ram_clearable #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 6,
   parameter int REG_OUT   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] address,
   input  logic                 clear,
   output logic [WIDTH-1:0]     out,
   output logic                 busy
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;
   localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0]     mem_q [DEPTH];

   logic                 wr_en;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [WIDTH-1:0]     wr_data;

   assign busy = (state_q == S_CLEAR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         S_IDLE: begin
            if (clear) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end
         end
         S_CLEAR: begin
            if (ptr_q == PTR_LAST) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + PTR_ONE;
            end
         end
         default: begin
            state_d = S_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   // The sweep owns the write port; in idle, a clear request drops a coincident load.
   // Memory is left untouched while reset is held.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = address;
      wr_data = in;
      if (!reset) begin
         if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = '0;
         end else if (!clear && load) begin
            wr_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [WIDTH-1:0] out_q;
         // Non-blocking read samples the pre-write word on a same-address write.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               out_q <= '0;
            end else if (busy) begin
               out_q <= '0;
            end else begin
               out_q <= mem_q[address];
            end
         end
         assign out = out_q;
      end else begin : g_comb_out
         assign out = busy ? '0 : mem_q[address];
      end
   endgenerate

endmodule
